// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with an iterative radix-2 multiply/divide unit.
// Single-cycle ops finish on the accept edge; MUL*/DIV*/REM* iterate DW cycles.
// Divide-by-zero and signed divide overflow bypass the iteration entirely.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a request; in_ready high
// S_BUSY | multiply/divide iterating, one step per cycle, cnt counts up
// S_DONE | result/less/zero held; out_valid high until out_ready
module alu_mdu #(
    parameter int DW  = 32,
    parameter int SHW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    op,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic          less,
    output logic          zero
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [DW-1:0]  MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [SHW-1:0] CNT_LAST = SHW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SHW-1:0]  cnt;
    logic [4:0]      op_q;
    logic            neg_q;
    logic [DW-1:0]   opnd_q;   // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*DW-1:0] acc;      // {hi, lo}: product accumulator or {remainder, quotient}

    // single-cycle datapath
    logic [DW:0]     diff_w;
    logic [DW-1:0]   diff;
    logic [SHW-1:0]  shamt;
    logic            ovf;
    logic            lt_s;
    logic            lt_u;
    logic [DW-1:0]   alu_res;
    logic            alu_less;

    // request classification and operand conditioning
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic [DW-1:0]   abs_a;
    logic [DW-1:0]   abs_b;
    logic            is_mul;
    logic            is_div;
    logic            div_zero;
    logic            div_ovf;
    logic            imm_iter;
    logic            imm_neg;
    logic [DW-1:0]   imm_res;

    // iteration step and final sign correction
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW:0]     div_shift;
    logic [DW:0]     div_trial;
    logic [2*DW-1:0] div_next;
    logic            q_is_mul;
    logic [2*DW-1:0] step;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   lo_fix;
    logic [DW-1:0]   hi_fix;
    logic [DW-1:0]   fin_res;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // one-cycle ALU: arithmetic, compares, logic and shifts on live operands
    always_comb begin
        diff_w   = {1'b0, opa} - {1'b0, opb};
        diff     = diff_w[DW-1:0];
        ovf      = (opa[DW-1] != opb[DW-1]) && (diff[DW-1] != opa[DW-1]);
        lt_s     = diff[DW-1] ^ ovf;
        lt_u     = diff_w[DW];
        shamt    = opb[SHW-1:0];
        alu_res  = '0;
        alu_less = 1'b0;
        case (op)
            OP_ADD:   alu_res = opa + opb;
            OP_SUB:   alu_res = diff;
            OP_SLL:   alu_res = opa << shamt;
            OP_SLT: begin
                alu_less = lt_s;
                alu_res  = {{(DW-1){1'b0}}, lt_s};
            end
            OP_SLTU: begin
                alu_less = lt_u;
                alu_res  = {{(DW-1){1'b0}}, lt_u};
            end
            OP_XOR:   alu_res = opa ^ opb;
            OP_SRL:   alu_res = opa >> shamt;
            OP_SRA:   alu_res = $signed(opa) >>> shamt;
            OP_OR:    alu_res = opa | opb;
            OP_AND:   alu_res = opa & opb;
            OP_PASSB: alu_res = opb;
            default: begin
                alu_res  = '0;
                alu_less = 1'b0;
            end
        endcase
    end

    // classify the request, build magnitudes and the result sign, catch divide special cases
    always_comb begin
        a_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
        b_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_sgn && opa[DW-1];
        b_neg    = b_sgn && opb[DW-1];
        abs_a    = a_neg ? (~opa + 1'b1) : opa;
        abs_b    = b_neg ? (~opb + 1'b1) : opb;
        is_mul   = (op >= OP_MUL) && (op <= OP_MULHU);
        is_div   = (op >= OP_DIV) && (op <= OP_REMU);
        div_zero = (opb == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (opa == MIN_NEG) && (opb == '1);
        imm_iter = is_mul || (is_div && !div_zero && !div_ovf);
        // remainder follows the dividend; quotient and product follow a XOR b
        imm_neg  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        if (is_div && div_zero) begin
            imm_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : opa;
        end else if (div_ovf) begin
            imm_res = (op == OP_DIV) ? opa : '0;
        end else begin
            imm_res = alu_res;
        end
    end

    // next accumulator value for one shift-add or restoring-divide step, plus the corrected result
    always_comb begin
        mul_sum   = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd_q} : {(DW+1){1'b0}});
        mul_next  = {mul_sum, acc[DW-1:1]};
        div_shift = {acc[2*DW-1:DW], acc[DW-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_next  = div_trial[DW] ? {div_shift[DW-1:0], acc[DW-2:0], 1'b0}
                                  : {div_trial[DW-1:0], acc[DW-2:0], 1'b1};
        q_is_mul  = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
        step      = q_is_mul ? mul_next : div_next;
        prod_fix  = neg_q ? (~step + 1'b1) : step;
        lo_fix    = neg_q ? (~step[DW-1:0] + 1'b1) : step[DW-1:0];
        hi_fix    = neg_q ? (~step[2*DW-1:DW] + 1'b1) : step[2*DW-1:DW];
        case (op_q)
            OP_MUL:                       fin_res = prod_fix[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*DW-1:DW];
            OP_DIV, OP_DIVU:              fin_res = lo_fix;
            OP_REM, OP_REMU:              fin_res = hi_fix;
            default:                      fin_res = '0;
        endcase
    end

    // control FSM with registered result, flags and iteration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc    <= '0;
            result <= '0;
            less   <= 1'b0;
            zero   <= 1'b1;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (imm_iter) begin
                            state  <= S_BUSY;
                            cnt    <= '0;
                            neg_q  <= imm_neg;
                            opnd_q <= is_mul ? abs_a : abs_b;
                            acc    <= {{DW{1'b0}}, (is_mul ? abs_b : abs_a)};
                        end else begin
                            state  <= S_DONE;
                            result <= imm_res;
                            less   <= alu_less;
                            zero   <= (imm_res == '0);
                        end
                    end
                end
                S_BUSY: begin
                    acc <= step;
                    if (cnt == CNT_LAST) begin
                        state  <= S_DONE;
                        cnt    <= '0;
                        result <= fin_res;
                        less   <= 1'b0;
                        zero   <= (fin_res == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (DW = 32) with hand-computed expected values.
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        less;
    logic        zero;

    int checks;
    int failures;

    alu_mdu #(.DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .less      (less),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency (accept edge counts as 1),
    // check outputs, optionally hold off out_ready, then retire it.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_less, input int hold);
        int lat;
        @(negedge clk);
        check_val({tag, "_in_ready"}, in_ready, 1);
        op = o; opa = a; opb = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'd1; opa = 32'hA5A5_5A5A; opb = 32'h0000_0003;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_res"}, result, exp_res);
        check_val({tag, "_less"}, less, exp_less);
        check_val({tag, "_zero"}, zero, (exp_res == 32'd0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_res"}, result, exp_res);
            check_val({tag, "_hold_in_ready"}, in_ready, 0);
            check_val({tag, "_hold_out_valid"}, out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_ret_out_valid"}, out_valid, 0);
        check_val({tag, "_ret_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        op = 5'd0; opa = '0; opb = '0;
        #23;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, 0);
        check_val("rst_less", less, 0);
        check_val("rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // single-cycle ops
        run_op("add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0, 0);
        run_op("slt",      5'd3,  32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 1'b1, 0);
        run_op("sltu",     5'd4,  32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0000, 1'b0, 0);
        run_op("sub",      5'd1,  32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("sll_mask", 5'd2,  32'h0000_0001, 32'h0000_0021, 1, 32'h0000_0002, 1'b0, 0);
        run_op("sra",      5'd7,  32'h8000_0000, 32'h0000_0004, 1, 32'hF800_0000, 1'b0, 0);
        run_op("srl",      5'd6,  32'h8000_0000, 32'h0000_0004, 1, 32'h0800_0000, 1'b0, 0);
        run_op("xor",      5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0, 0);
        run_op("or",       5'd8,  32'hF0F0_F0F0, 32'h0F0F_0000, 1, 32'hFFFF_F0F0, 1'b0, 0);
        run_op("and",      5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 0);
        run_op("passb",    5'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 0);
        run_op("undef",    5'd11, 32'h0000_0003, 32'h0000_0004, 1, 32'h0000_0000, 1'b0, 0);

        // multiply
        run_op("mulh",     5'd17, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mul",      5'd16, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("mulhu",    5'd19, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'h0000_0001, 1'b0, 0);
        run_op("mulhsu",   5'd18, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32'h0000_0001, 1'b0, 0);
        run_op("mulh_sn",  5'd17, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, 1'b0, 0);

        // divide
        run_op("div_m7_2", 5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_m7_2", 5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu_hold",5'd21, 32'd100,       32'd7,         33, 32'd14,        1'b0, 10);
        run_op("remu",     5'd23, 32'd100,       32'd7,         33, 32'd2,         1'b0, 0);
        run_op("div_7_m2", 5'd20, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_7_m2", 5'd22, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 1'b0, 0);
        run_op("divu_big", 5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 1'b0, 0);

        // short-circuit divide cases
        run_op("div_z",    5'd20, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("rem_z",    5'd22, 32'd5,         32'd0,         1, 32'd5,         1'b0, 0);
        run_op("divu_z",   5'd21, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("remu_z",   5'd23, 32'd5,         32'd0,         1, 32'd5,         1'b0, 0);
        run_op("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0, 0);
        run_op("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0, 0);

        // flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        op = 5'd0; opa = 32'd1; opb = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_val("flush_idle_in_ready", in_ready, 1);
        check_val("flush_idle_out_valid", out_valid, 0);

        // flush 5 cycles into MULHU
        @(negedge clk);
        op = 5'd19; opa = 32'hFFFF_FFFF; opb = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("flush_busy_in_ready", in_ready, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check_val("flush_no_out_valid", seen, 0);

        // leave a nonzero result with less set, then reset in the middle of a DIV
        run_op("slt_pre",  5'd3,  32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 1'b1, 0);
        @(negedge clk);
        op = 5'd20; opa = 32'hFFFF_FFF9; opb = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", in_ready, 1);
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_result", result, 0);
        check_val("mid_rst_less", less, 0);
        check_val("mid_rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_3_4",  5'd0,  32'd3,         32'd4,         1, 32'd7,         1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle ALU for the next core generation. It executes every existing ALU operation in one registered cycle. It adds an iterative radix-2 multiply/divide unit (RV32M/RV64M semantics) that takes DW cycles. It sits in the execute stage behind a valid/ready handshake, so the pipeline stalls on long operations instead of lengthening the critical path.

## Interface
- DW, default 32: operand/result width; must be a power of two and ≥ 8.
- SHW, default $clog2(DW): shift-amount width; taken from opb[SHW-1:0].
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation code (list below).
- opa, opb  in  DW  operands.
- flush  in  1  synchronous abort; highest priority.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  DW  registered result.
- less  out  1  registered signed/unsigned compare flag; valid for ops 3/4, otherwise 0.
- zero  out  1  registered flag; high when result == 0.

## Operation
- Single-cycle ops:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (result = opb).
  - SLT/SLTU: result = {DW-1 zeros, less}.
  - Signed less = sign(a−b) XOR overflow; unsigned less = borrow out of a−b.
- Iterative ops:
  - 16 MUL (low DW of product), 17 MULH (s×s), 18 MULHSU (s×u), 19 MULHU (u×u).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Undefined op codes complete in one cycle with result = 0, less = 0, zero = 1.
- Arithmetic rules:
  - Add/sub wrap modulo 2^DW. Shifts use only opb[SHW-1:0].
  - Multiply: operands converted to magnitudes, shift-add over DW iterations into a 2·DW accumulator. Sign correction (two's-complement negate) is applied on the BUSY→DONE transition.
  - Divide: restoring division on magnitudes, one quotient bit per iteration. Quotient takes the sign a XOR b; remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = opa.
  - Signed overflow (opa = 100…0, opb = all ones): DIV result = opa; REM result = 0.
  - Both divide cases above short-circuit: they complete with single-cycle latency and never enter BUSY.
- State machine:
  - IDLE: in_ready = 1. On in_valid:
    - single-cycle or short-circuit op → DONE with the result registered;
    - iterative op → BUSY, operands latched, cnt = 0.
  - BUSY: one iteration per cycle; cnt increments. When cnt == DW−1 → DONE with the final corrected result.
  - DONE: out_valid = 1; result/less/zero held stable. When out_ready → IDLE.
  - flush in any state → IDLE next cycle; the in-flight op is discarded and no out_valid pulse occurs. Flush in IDLE together with in_valid: the request is not accepted.
- Operands are sampled only at acceptance. Changes to opa/opb/op while BUSY or DONE have no effect.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 1, out_valid = 0, result = 0, less = 0, zero = 1, cnt = 0. Internal accumulators are cleared.
- Releasing reset mid-operation: the op is lost; the unit restarts in IDLE.
- Latency from the accept edge to out_valid high:
  - single-cycle, undefined and short-circuit ops: 1 cycle;
  - iterative ops: DW+1 cycles (DW in BUSY plus the DONE entry).
- Throughput: no back-to-back accept. in_ready is low in DONE, so the next accept is at the earliest the cycle after out_valid·out_ready. Sustained rate for single-cycle ops is one op per 2 cycles.
- Backpressure: out_valid stays high and result is stable until out_ready; holding for any number of cycles loses nothing.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid, out_ready or flush.

## Test plan
- Reset, then ADD with opa = 0x7FFFFFFF, opb = 1, DW = 32 → out_valid 1 cycle after accept; result = 0x80000000, zero = 0. SLT with opa = 0x80000000, opb = 1 → less = 1, result = 1; SLTU with the same operands → less = 0.
- MULH with opa = 0xFFFFFFFF (−1), opb = 0x00000002 → out_valid exactly 33 cycles after accept; result = 0xFFFFFFFF. MUL with the same operands → result = 0xFFFFFFFE. MULHU with the same operands → result = 0x00000001.
- DIV −7/2 → result 0xFFFFFFFD; REM −7/2 → result 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each takes 33 cycles.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0, zero = 1. All four in 1 cycle, with no BUSY entry.
- Hold out_ready low for 10 cycles after a DIVU completes → result held constant and in_ready stays 0; on the out_ready pulse, IDLE follows the next cycle.
- Assert flush 5 cycles into a MULHU → IDLE next cycle, no out_valid pulse. Pulse rst_n low mid-DIV → outputs are at reset values immediately. A subsequent ADD 3+4 → 7.
